// File: rtl/display_pkg.sv
// Shared constants, glyph table and state encoding for the
// signed BCD seven-segment display driver.
package display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Active-low {g,f,e,d,c,b,a}; index 15 first down to index 0
   localparam logic [15:0][6:0] SEG_DIGIT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_STORE
   } state_t;

   // ceil(width*log10(2) + 1); width*log10(2) is never an integer
   function automatic int bcd_digits(input int width);
      return (width * 30103) / 100000 + 2;
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to active-low seven-segment glyph, with dash and
// blank overrides (dash wins).
module seg7_glyph
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DIGIT[nibble];
      if (blank) seg = SEG_BLANK;
      if (dash)  seg = SEG_DASH;
   end

endmodule

// File: rtl/signed_bcd_display.sv
// Multi-channel signed/hex value to seven-segment driver using one
// shared iterative double-dabble engine, refreshed per tick.
module signed_bcd_display
   import display_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int VAL_WIDTH  = 12,
   parameter int NUM_DIGITS = 3
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_tick,
   input  logic [NUM_CH*VAL_WIDTH-1:0]        i_value,
   input  logic [NUM_CH-1:0]                  i_hex,
   output logic [NUM_CH*(NUM_DIGITS+1)*7-1:0] o_seg,
   output logic                               o_busy,
   output logic                               o_done
);

   localparam int CH_SEG = (NUM_DIGITS + 1) * 7;
   localparam int BCD_N  = bcd_digits(VAL_WIDTH);
   localparam int BCD_W  = 4 * BCD_N;
   localparam int PAD_W  = 4 * NUM_DIGITS;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W  = $clog2(VAL_WIDTH + 1);

   state_t state, state_nx;

   logic [CH_W-1:0]          ch_idx;
   logic [CNT_W-1:0]         bit_cnt;
   logic                     pending;
   logic [VAL_WIDTH-1:0]     val_q, mag_q, in_val;
   logic                     neg_q, hex_q;
   logic [BCD_W-1:0]         bcd_q, bcd_adj;
   logic [NUM_CH*CH_SEG-1:0] seg_q;

   logic go, last_ch;
   logic start_en, load_en, shift_en, store_en;

   assign go      = i_tick | pending;
   assign last_ch = ch_idx == CH_W'(NUM_CH - 1);
   assign in_val  = i_value[ch_idx*VAL_WIDTH +: VAL_WIDTH];
   assign o_seg   = seg_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (go) state_nx = ST_LOAD;
         ST_LOAD:  state_nx = ST_SHIFT;
         ST_SHIFT: if (bit_cnt == CNT_W'(1)) state_nx = ST_STORE;
         ST_STORE: state_nx = last_ch ? ST_IDLE : ST_LOAD;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      start_en = 1'b0;
      load_en  = 1'b0;
      shift_en = 1'b0;
      store_en = 1'b0;
      unique case (state)
         ST_IDLE:  start_en = go;
         ST_LOAD:  load_en  = 1'b1;
         ST_SHIFT: shift_en = 1'b1;
         ST_STORE: store_en = 1'b1;
         default:  ;
      endcase
   end

   // Add-3 correction applied before each left shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_N; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   logic [BCD_W+PAD_W-1:0]     bcd_ext;
   logic [VAL_WIDTH+PAD_W-1:0] val_ext;
   logic                       ovf, sign_dash;
   logic [3:0]                 nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]      zero_top, blank_d, dash_d;
   logic [CH_SEG-1:0]          glyphs;

   assign bcd_ext   = {{PAD_W{1'b0}}, bcd_q};
   assign val_ext   = {{PAD_W{1'b0}}, val_q};
   assign ovf       = |bcd_ext[BCD_W+PAD_W-1:PAD_W];
   assign sign_dash = ~hex_q & neg_q & (|bcd_q);

   always_comb begin
      logic above;
      above = 1'b1;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         nib[d]      = hex_q ? val_ext[4*d +: 4] : bcd_ext[4*d +: 4];
         above       = above & (bcd_ext[4*d +: 4] == 4'd0);
         zero_top[d] = above;
         blank_d[d]  = ~hex_q & ~ovf & (d != 0) & above;
         dash_d[d]   = ~hex_q & ovf;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      seg7_glyph u_glyph (
         .nibble (nib[g]),
         .blank  (blank_d[g]),
         .dash   (dash_d[g]),
         .seg    (glyphs[g*7 +: 7])
      );
   end

   seg7_glyph u_sign (
      .nibble (4'd0),
      .blank  (1'b1),
      .dash   (sign_dash),
      .seg    (glyphs[NUM_DIGITS*7 +: 7])
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         seg_q   <= '1;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         pending <= 1'b0;
         ch_idx  <= '0;
         bit_cnt <= '0;
         val_q   <= '0;
         mag_q   <= '0;
         neg_q   <= 1'b0;
         hex_q   <= 1'b0;
         bcd_q   <= '0;
      end else begin
         o_done <= 1'b0;
         if (i_tick && o_busy) pending <= 1'b1;
         if (start_en) begin
            o_busy  <= 1'b1;
            ch_idx  <= '0;
            pending <= 1'b0;
         end
         if (load_en) begin
            val_q   <= in_val;
            neg_q   <= in_val[VAL_WIDTH-1];
            mag_q   <= in_val[VAL_WIDTH-1] ? (~in_val + VAL_WIDTH'(1)) : in_val;
            hex_q   <= i_hex[ch_idx];
            bcd_q   <= '0;
            bit_cnt <= CNT_W'(VAL_WIDTH);
         end
         if (shift_en) begin
            bcd_q   <= {bcd_adj[BCD_W-2:0], mag_q[VAL_WIDTH-1]};
            mag_q   <= mag_q << 1;
            bit_cnt <= bit_cnt - CNT_W'(1);
         end
         if (store_en) begin
            seg_q[ch_idx*CH_SEG +: CH_SEG] <= glyphs;
            if (last_ch) begin
               ch_idx <= '0;
               o_busy <= 1'b0;
               o_done <= 1'b1;
            end else begin
               ch_idx <= ch_idx + CH_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_signed_bcd_display.sv
// Self-checking bench: fixed vectors, handshake/reset sequences and
// random sweeps against an arithmetic reference model.
module tb_signed_bcd_display;

   localparam logic [6:0] BL = 7'h7F;
   localparam logic [6:0] DS = 7'h3F;
   localparam logic [6:0] GL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic [23:0] value = '0;
   logic [1:0]  hex = '0;
   logic [55:0] seg;
   logic        busy, done;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   signed_bcd_display dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_tick  (tick),
      .i_value (value),
      .i_hex   (hex),
      .o_seg   (seg),
      .o_busy  (busy),
      .o_done  (done)
   );

   typedef struct {
      logic [11:0] v0;
      logic [11:0] v1;
      bit          h0;
      bit          h1;
      logic [27:0] e0;
      logic [27:0] e1;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [27:0] model_ch(input logic [11:0] raw, input bit hx);
      int v, mag;
      logic [27:0] r;
      v   = int'($signed(raw));
      mag = (v < 0) ? -v : v;
      if (hx)
         r = {BL, GL[raw[11:8]], GL[raw[7:4]], GL[raw[3:0]]};
      else if (mag >= 1000)
         r = {(v < 0) ? DS : BL, DS, DS, DS};
      else
         r = {(v < 0 && mag != 0) ? DS : BL,
              (mag >= 100) ? GL[mag / 100] : BL,
              (mag >= 10) ? GL[(mag / 10) % 10] : BL,
              GL[mag % 10]};
      return r;
   endfunction

   // Starts at a negedge; returns cycles from tick to o_done visible
   task automatic sweep(input logic [11:0] v0, input logic [11:0] v1,
                        input bit h0, input bit h1, output int lat);
      value = {v1, v0};
      hex   = {h1, h0};
      tick  = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      lat  = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, ndone, first, second;
      bit saw_busy;
      logic busy30;
      logic [55:0] seg15, seg29, prev;
      logic [11:0] r0, r1;
      bit rh0, rh1;

      vecs[0] = '{12'(-135), 12'd42, 0, 0,
                  {DS, GL[1], GL[3], GL[5]}, {BL, BL, GL[4], GL[2]}};
      vecs[1] = '{12'h800, 12'd0, 0, 0,
                  {DS, DS, DS, DS}, {BL, BL, BL, GL[0]}};
      vecs[2] = '{12'hABC, 12'hFFF, 1, 0,
                  {BL, GL[10], GL[11], GL[12]}, {DS, BL, BL, GL[1]}};
      vecs[3] = '{12'd999, 12'(-999), 0, 0,
                  {BL, GL[9], GL[9], GL[9]}, {DS, GL[9], GL[9], GL[9]}};
      vecs[4] = '{12'd1000, 12'(-1000), 0, 0,
                  {BL, DS, DS, DS}, {DS, DS, DS, DS}};
      vecs[5] = '{12'h7FF, 12'd100, 1, 0,
                  {BL, GL[7], GL[15], GL[15]}, {BL, GL[1], GL[0], GL[0]}};
      vecs[6] = '{12'h000, 12'(-10), 1, 0,
                  {BL, GL[0], GL[0], GL[0]}, {DS, BL, GL[1], GL[0]}};
      vecs[7] = '{12'h800, 12'd7, 1, 0,
                  {BL, GL[8], GL[0], GL[0]}, {BL, BL, BL, GL[7]}};

      // Reset and idle behaviour
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_seg", seg, {56{1'b1}});
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      saw_busy = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy || done) saw_busy = 1;
      end
      chk("idle_no_activity", saw_busy, 0);

      // Fixed vectors
      foreach (vecs[i]) begin
         sweep(vecs[i].v0, vecs[i].v1, vecs[i].h0, vecs[i].h1, lat);
         chk($sformatf("vec%0d_latency", i), lat, 29);
         chk($sformatf("vec%0d_busy_low", i), busy, 0);
         chk($sformatf("vec%0d_seg", i), seg, {vecs[i].e1, vecs[i].e0});
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), done, 0);
      end
      prev = {vecs[7].e1, vecs[7].e0};

      // Ticks while busy merge into one follow-up sweep
      value = {12'd5, 12'd300};
      hex   = 2'b00;
      tick  = 1'b1;
      @(negedge clk);
      tick   = 1'b0;
      ndone  = 0;
      first  = 0;
      second = 0;
      busy30 = 1'b0;
      seg15  = '0;
      seg29  = '0;
      for (int c = 1; c <= 80; c++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) first = c;
            else second = c;
         end
         if (c == 15) seg15 = seg;
         if (c == 29) seg29 = seg;
         if (c == 30) busy30 = busy;
         tick = (c == 5 || c == 10);
         if (c == 12) value[11:0] = 12'd7;
         @(negedge clk);
      end
      tick = 1'b0;
      chk("pend_first_done", first, 29);
      chk("pend_second_done", second, 58);
      chk("pend_done_count", ndone, 2);
      chk("pend_restart_busy", busy30, 1);
      chk("hold_ch1_mid_sweep", seg15, {prev[55:28], BL, GL[3], GL[0], GL[0]});
      chk("snapshot_ch0", seg29, {BL, BL, BL, GL[5], BL, GL[3], GL[0], GL[0]});
      chk("pend_final_seg", seg, {BL, BL, BL, GL[5], BL, BL, BL, GL[7]});

      // Reset in the middle of a sweep
      value = {12'd1, 12'd2};
      tick  = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_seg", seg, {56{1'b1}});
      chk("midrst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      sweep(12'(-42), 12'd314, 0, 0, lat);
      chk("post_rst_latency", lat, 29);
      chk("post_rst_seg", seg, {model_ch(12'd314, 0), model_ch(12'(-42), 0)});
      @(negedge clk);

      // Random sweeps against the reference model
      for (int i = 0; i < 30; i++) begin
         r0  = 12'($urandom);
         r1  = 12'($urandom_range(0, 2200));
         rh0 = 1'($urandom);
         rh1 = 1'($urandom);
         if (i % 3 == 0) r1 = -r1;
         sweep(r0, r1, rh0, rh1, lat);
         chk($sformatf("rand%0d_latency", i), lat, 29);
         chk($sformatf("rand%0d_seg", i), seg, {model_ch(r1, rh1), model_ch(r0, rh0)});
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
